// File: rtl/sel_ser_pkg.sv
// sel_ser_pkg: shared types and helpers for the sel_ser line-to-word serializer.
// Contents: state_e (serializer FSM states), idx_w() (word index width for N words).
package sel_ser_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sel_ser_sel.sv
// sel: word mux picking word i_sel out of an N-word line.
// Ports: i_x   - W-bit line, word k = i_x[OUT_W*k +: OUT_W]
//        i_sel - word index
//        o_y   - selected OUT_W-bit word (zero for an out-of-range index)
module sel
    import sel_ser_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4,
    localparam int OUT_W = W / N,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [W-1:0]     i_x,
    input  logic [IDX_W-1:0] i_sel,
    output logic [OUT_W-1:0] o_y
);

    logic [OUT_W-1:0] words [N];

    for (genvar k = 0; k < N; k++) begin : g_w
        assign words[k] = i_x[k*OUT_W +: OUT_W];
    end

    assign o_y = (int'(i_sel) < N) ? words[i_sel] : '0;

endmodule

// File: rtl/sel_ser.sv
// sel_ser: registers one W-bit line and emits its words LSB-first, stopping at a per-line last index.
// Ports: clk, rst (sync, active-high)
//        i_in_vld / i_in_data / i_in_last_idx / o_in_rdy - line input handshake
//        o_out_vld / o_out_data / o_out_idx / o_out_last / i_out_rdy - word output handshake
module sel_ser
    import sel_ser_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4,
    localparam int OUT_W = W / N,
    localparam int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_vld,
    input  logic [W-1:0]     i_in_data,
    input  logic [IDX_W-1:0] i_in_last_idx,
    output logic             o_in_rdy,
    output logic             o_out_vld,
    output logic [OUT_W-1:0] o_out_data,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    input  logic             i_out_rdy
);

    state_e           state_q, state_d;
    logic [W-1:0]     line_q, line_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] last_in;
    logic [OUT_W-1:0] word;
    logic             beat, acc, done;

    sel #(.W(W), .N(N)) u_sel (
        .i_x   (line_q),
        .i_sel (idx_q),
        .o_y   (word)
    );

    // Out-of-range last indices only exist for non-power-of-2 N.
    assign last_in = (int'(i_in_last_idx) > N - 1) ? IDX_W'(N - 1) : i_in_last_idx;

    assign o_out_vld  = ~rst & (state_q == BUSY);
    assign o_out_data = rst ? '0 : word;
    assign o_out_idx  = rst ? '0 : idx_q;
    assign o_out_last = ~rst & (idx_q == last_q);
    assign beat       = o_out_vld & i_out_rdy;
    assign done       = beat & o_out_last;
    // A new line may load during the final beat so lines stream without a bubble.
    assign o_in_rdy   = ~rst & ((state_q == IDLE) | done);
    assign acc        = i_in_vld & o_in_rdy;

    always_comb begin
        state_d = acc ? BUSY : done ? IDLE : state_q;
        idx_d   = (acc | done) ? '0 : beat ? idx_q + 1'b1 : idx_q;
        last_d  = acc ? last_in : last_q;
        line_d  = acc ? i_in_data : line_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

`ifndef SYNTHESIS
    if (W % N != 0) begin : g_chk
        $error("sel_ser: W must be a multiple of N");
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        o_out_vld & ~i_out_rdy |=> o_out_vld & $stable(o_out_data) & $stable(o_out_idx) & $stable(o_out_last));
    a_idle: assert property (@(posedge clk) ~((state_q == IDLE) & o_out_vld));
    a_last: assert property (@(posedge clk) int'(last_q) < N);
`endif

endmodule

// File: tb/tb_sel_ser.sv
// tb_sel_ser: directed table-driven bench for sel_ser (W=32,N=4) plus a clamp sequence on W=24,N=3.
module tb_sel_ser;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic [1:0]  li;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_dat;
        logic [1:0]  e_idx;
        logic        e_last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0, ordy = 1'b0;
    logic [31:0] d = '0;
    logic [1:0]  li = '0;
    logic        in_rdy, out_vld, out_last;
    logic [7:0]  out_dat;
    logic [1:0]  out_idx;

    logic        vld3 = 1'b0, ordy3 = 1'b0;
    logic [23:0] d3 = '0;
    logic [1:0]  li3 = '0;
    logic        in_rdy3, out_vld3, out_last3;
    logic [7:0]  out_dat3;
    logic [1:0]  out_idx3;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    sel_ser #(.W(32), .N(4)) u_dut (
        .clk(clk), .rst(rst),
        .i_in_vld(vld), .i_in_data(d), .i_in_last_idx(li), .o_in_rdy(in_rdy),
        .o_out_vld(out_vld), .o_out_data(out_dat), .o_out_idx(out_idx), .o_out_last(out_last),
        .i_out_rdy(ordy)
    );

    sel_ser #(.W(24), .N(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_in_vld(vld3), .i_in_data(d3), .i_in_last_idx(li3), .o_in_rdy(in_rdy3),
        .o_out_vld(out_vld3), .o_out_data(out_dat3), .o_out_idx(out_idx3), .o_out_last(out_last3),
        .i_out_rdy(ordy3)
    );

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [31:0] dd, input logic [1:0] l,
                       input logic o, input logic er, input logic ev, input logic [7:0] ed,
                       input logic [1:0] ei, input logic el);
        tbl.push_back('{r, v, dd, l, o, er, ev, ed, ei, el});
    endtask

    initial begin
        add(1, 0, 32'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 32'hDDCCBBAA, 3, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hAA, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hBB, 1, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hCC, 2, 0);
        add(0, 0, 32'h0, 0, 1, 1, 1, 8'hDD, 3, 1);
        add(0, 1, 32'h44332211, 1, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, 1, 8'h22, 1, 1);
        add(0, 1, 32'hDDCCBBAA, 3, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hAA, 0, 0);
        add(0, 0, 32'h0, 0, 0, 0, 1, 8'hBB, 1, 0);
        add(0, 1, 32'h12345678, 0, 0, 0, 1, 8'hBB, 1, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hBB, 1, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hCC, 2, 0);
        add(0, 1, 32'h87654321, 3, 1, 1, 1, 8'hDD, 3, 1);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h21, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h43, 1, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h65, 2, 0);
        add(0, 0, 32'h0, 0, 1, 1, 1, 8'h87, 3, 1);
        add(0, 1, 32'hDDCCBBAA, 3, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'hAA, 0, 0);
        add(1, 0, 32'h0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 32'h0F0E0D0C, 3, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h0C, 0, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h0D, 1, 0);
        add(0, 0, 32'h0, 0, 1, 0, 1, 8'h0E, 2, 0);
        add(0, 0, 32'h0, 0, 1, 1, 1, 8'h0F, 3, 1);
        add(0, 1, 32'h000000EE, 0, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 32'h0, 0, 1, 1, 1, 8'hEE, 0, 1);
        add(0, 0, 32'h0, 0, 1, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].r; vld = tbl[i].v; d = tbl[i].d; li = tbl[i].li; ordy = tbl[i].ordy;
            #1;
            chk("in_rdy", i, 32'(in_rdy), 32'(tbl[i].e_rdy));
            chk("out_vld", i, 32'(out_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld | tbl[i].r) begin
                chk("out_data", i, 32'(out_dat), 32'(tbl[i].e_dat));
                chk("out_idx", i, 32'(out_idx), 32'(tbl[i].e_idx));
                chk("out_last", i, 32'(out_last), 32'(tbl[i].e_last));
            end
        end

        @(negedge clk);
        vld = 1'b0;
        vld3 = 1'b1; d3 = 24'hCCBBAA; li3 = 2'd3; ordy3 = 1'b1;
        #1;
        chk("n3_in_rdy", 0, 32'(in_rdy3), 32'd1);
        chk("n3_out_vld", 0, 32'(out_vld3), 32'd0);
        @(negedge clk);
        vld3 = 1'b0;
        #1;
        chk("n3_data", 1, 32'(out_dat3), 32'hAA);
        chk("n3_idx", 1, 32'(out_idx3), 32'd0);
        chk("n3_last", 1, 32'(out_last3), 32'd0);
        @(negedge clk);
        #1;
        chk("n3_data", 2, 32'(out_dat3), 32'hBB);
        chk("n3_idx", 2, 32'(out_idx3), 32'd1);
        chk("n3_last", 2, 32'(out_last3), 32'd0);
        @(negedge clk);
        #1;
        chk("n3_data", 3, 32'(out_dat3), 32'hCC);
        chk("n3_idx", 3, 32'(out_idx3), 32'd2);
        chk("n3_last", 3, 32'(out_last3), 32'd1);
        chk("n3_in_rdy", 3, 32'(in_rdy3), 32'd1);
        @(negedge clk);
        #1;
        chk("n3_out_vld", 4, 32'(out_vld3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
